// File: rtl/cache_edc_checker_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cache_edc_checker_pkg
// Purpose  : Shared SECDED constants, codeword position map and FSM encodings
//            for the cache EDC checker.
// Revision : 1.0 - initial release
// ============================================================================
package cache_edc_checker_pkg;

  localparam int CHK_BITS = 6;   // Hamming check bits c[5:0]
  localparam int PAR_IDX  = 6;   // index of the overall-parity bit
  localparam int CW_LEN   = 38;  // highest Hamming codeword position
  localparam int DATA_W   = 32;

  // FSM state encodings
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_CHECK = 2'd2;
  localparam logic [1:0] ST_SCRUB = 2'd3;

  // Codeword position of data bit k: the k-th non-power-of-two position in 1..38.
  function automatic logic [5:0] data_pos(input int k);
    int n;
    logic [5:0] pos;
    n   = 0;
    pos = '0;
    for (int p = 1; p <= CW_LEN; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (n == k) pos = 6'(p);
        n++;
      end
    end
    return pos;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cache_edc_checker_enc.sv
`default_nettype none
// ============================================================================
// Module   : edc_secded_enc
// Purpose  : Combinational 32-bit SECDED encoder producing six Hamming check
//            bits plus the overall parity bit in chk[6].
// Revision : 1.0 - initial release
// ============================================================================
module edc_secded_enc
  import cache_edc_checker_pkg::*;
(
  input  logic [DATA_W-1:0] data,
  output logic [6:0]        chk
);

  logic [CHK_BITS-1:0] c;
  logic [5:0]          pos;

  // Each data bit toggles the check bits selected by its codeword position
  always_comb begin
    c   = '0;
    pos = '0;
    for (int k = 0; k < DATA_W; k++) begin
      pos = data_pos(k);
      c   = c ^ ({CHK_BITS{data[k]}} & pos);
    end
    chk = {(^data) ^ (^c), c};
  end

endmodule
`default_nettype wire

// File: rtl/cache_edc_checker.sv
`default_nettype none
// ============================================================================
// Module   : cache_edc_checker
// Purpose  : SECDED checker on the cache load path. Reads a word and its
//            check field, corrects single errors, flags double errors,
//            scrubs corrected words back and counts errors (saturating).
// Revision : 1.0 - initial release
// ============================================================================
module cache_edc_checker
  import cache_edc_checker_pkg::*;
#(
  parameter int ADDR_W   = 9,
  parameter int PAR_W    = 16,
  parameter int CNT_W    = 16,
  parameter int SCRUB_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_valid,
  output logic              rd_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              arr_re,
  output logic              arr_we,
  output logic [ADDR_W-1:0] arr_addr,
  input  logic [31:0]       arr_dout,
  input  logic [PAR_W-1:0]  arr_pout,
  output logic [31:0]       arr_din,
  output logic [PAR_W-1:0]  arr_pin,
  output logic              rsp_valid,
  output logic [31:0]       rsp_data,
  output logic              rsp_corr,
  output logic              rsp_uncorr,
  output logic [CNT_W-1:0]  corr_cnt,
  output logic [CNT_W-1:0]  uncorr_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_data_q, rsp_data_d;
  logic              rsp_corr_q, rsp_corr_d;
  logic              rsp_uncorr_q, rsp_uncorr_d;
  logic [31:0]       scrub_data_q, scrub_data_d;
  logic [CNT_W-1:0]  corr_cnt_q, corr_cnt_d;
  logic [CNT_W-1:0]  uncorr_cnt_q, uncorr_cnt_d;

  logic [6:0]        recomp_chk;
  logic [6:0]        scrub_chk;
  logic [5:0]        syn;
  logic              par;
  logic [31:0]       flip_mask;
  logic              syn_pow2;
  logic              dec_corr;
  logic              dec_uncorr;
  logic [31:0]       dec_data;

  // Only the low seven check-field bits carry code information
  logic unused_par_hi;
  assign unused_par_hi = ^arr_pout[PAR_W-1:7];

  edc_secded_enc u_enc_syn (
    .data (arr_dout),
    .chk  (recomp_chk)
  );

  edc_secded_enc u_enc_scrub (
    .data (scrub_data_q),
    .chk  (scrub_chk)
  );

  // Syndrome decode of the word returned by the array
  always_comb begin
    syn = recomp_chk[5:0] ^ arr_pout[5:0];
    // Overall parity of stored bits and data, rewritten via the recomputed parity
    par = arr_pout[PAR_IDX] ^ recomp_chk[PAR_IDX] ^ (^syn);
    flip_mask = '0;
    for (int k = 0; k < DATA_W; k++) begin
      if (data_pos(k) == syn) flip_mask[k] = 1'b1;
    end
    syn_pow2   = (syn != '0) && ((syn & (syn - 6'd1)) == '0);
    dec_corr   = par && ((syn == '0) || syn_pow2 || (flip_mask != '0));
    dec_uncorr = !dec_corr && (par || (syn != '0));
    dec_data   = dec_corr ? (arr_dout ^ flip_mask) : arr_dout;
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_corr_q   <= 1'b0;
      rsp_uncorr_q <= 1'b0;
      scrub_data_q <= '0;
      corr_cnt_q   <= '0;
      uncorr_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_corr_q   <= rsp_corr_d;
      rsp_uncorr_q <= rsp_uncorr_d;
      scrub_data_q <= scrub_data_d;
      corr_cnt_q   <= corr_cnt_d;
      uncorr_cnt_q <= uncorr_cnt_d;
    end
  end

  // Next-state logic: IDLE -> READ -> CHECK -> (SCRUB) -> IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (rd_valid) state_d = ST_READ;
      ST_READ:  state_d = ST_CHECK;
      ST_CHECK: state_d = (dec_corr && (SCRUB_EN != 0)) ? ST_SCRUB : ST_IDLE;
      ST_SCRUB: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Datapath next values: latch address, capture response, bump counters
  always_comb begin
    addr_d       = addr_q;
    rsp_valid_d  = 1'b0;
    rsp_data_d   = rsp_data_q;
    rsp_corr_d   = rsp_corr_q;
    rsp_uncorr_d = rsp_uncorr_q;
    scrub_data_d = scrub_data_q;
    corr_cnt_d   = corr_cnt_q;
    uncorr_cnt_d = uncorr_cnt_q;
    if ((state_q == ST_IDLE) && rd_valid) addr_d = rd_addr;
    if (state_q == ST_CHECK) begin
      rsp_valid_d  = 1'b1;
      rsp_data_d   = dec_data;
      rsp_corr_d   = dec_corr;
      rsp_uncorr_d = dec_uncorr;
      scrub_data_d = dec_data;
      if (dec_corr && (corr_cnt_q != CNT_MAX))
        corr_cnt_d = corr_cnt_q + CNT_W'(1);
      if (dec_uncorr && (uncorr_cnt_q != CNT_MAX))
        uncorr_cnt_d = uncorr_cnt_q + CNT_W'(1);
    end
  end

  // State-decoded array and handshake outputs
  always_comb begin
    rd_ready = 1'b0;
    arr_re   = 1'b0;
    arr_we   = 1'b0;
    arr_addr = '0;
    arr_din  = '0;
    arr_pin  = '0;
    case (state_q)
      ST_IDLE:  rd_ready = 1'b1;
      ST_READ: begin
        arr_re   = 1'b1;
        arr_addr = addr_q;
      end
      ST_SCRUB: begin
        arr_we       = 1'b1;
        arr_addr     = addr_q;
        arr_din      = scrub_data_q;
        arr_pin[6:0] = scrub_chk;
      end
      default: ;
    endcase
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_corr   = rsp_corr_q;
  assign rsp_uncorr = rsp_uncorr_q;
  assign corr_cnt   = corr_cnt_q;
  assign uncorr_cnt = uncorr_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_cache_edc_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_edc_checker
// Purpose  : Self-checking bench for cache_edc_checker with a word-level
//            SECDED reference model and a behavioural array.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cache_edc_checker;

  localparam int ADDR_W = 9;
  localparam int PAR_W  = 16;
  localparam int CNT_W  = 16;
  localparam int SAT_W  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              rd_valid;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_ready;
  logic              arr_re, arr_we;
  logic [ADDR_W-1:0] arr_addr;
  logic [31:0]       arr_dout;
  logic [PAR_W-1:0]  arr_pout;
  logic [31:0]       arr_din;
  logic [PAR_W-1:0]  arr_pin;
  logic              rsp_valid, rsp_corr, rsp_uncorr;
  logic [31:0]       rsp_data;
  logic [CNT_W-1:0]  corr_cnt, uncorr_cnt;

  // narrow-counter instance sharing the same stimulus and array
  logic              s_rd_ready, s_arr_re, s_arr_we, s_rsp_valid, s_rsp_corr, s_rsp_uncorr;
  logic [ADDR_W-1:0] s_arr_addr;
  logic [31:0]       s_arr_din, s_rsp_data;
  logic [PAR_W-1:0]  s_arr_pin;
  logic [SAT_W-1:0]  s_corr_cnt, s_uncorr_cnt;

  always #5 clk = ~clk;

  cache_edc_checker #(.ADDR_W(ADDR_W), .PAR_W(PAR_W), .CNT_W(CNT_W), .SCRUB_EN(1)) dut (
    .clk(clk), .rst(rst), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
    .arr_re(arr_re), .arr_we(arr_we), .arr_addr(arr_addr), .arr_dout(arr_dout),
    .arr_pout(arr_pout), .arr_din(arr_din), .arr_pin(arr_pin), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .rsp_corr(rsp_corr), .rsp_uncorr(rsp_uncorr),
    .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt)
  );

  cache_edc_checker #(.ADDR_W(ADDR_W), .PAR_W(PAR_W), .CNT_W(SAT_W), .SCRUB_EN(1)) dut_sat (
    .clk(clk), .rst(rst), .rd_valid(rd_valid), .rd_ready(s_rd_ready), .rd_addr(rd_addr),
    .arr_re(s_arr_re), .arr_we(s_arr_we), .arr_addr(s_arr_addr), .arr_dout(arr_dout),
    .arr_pout(arr_pout), .arr_din(s_arr_din), .arr_pin(s_arr_pin), .rsp_valid(s_rsp_valid),
    .rsp_data(s_rsp_data), .rsp_corr(s_rsp_corr), .rsp_uncorr(s_rsp_uncorr),
    .corr_cnt(s_corr_cnt), .uncorr_cnt(s_uncorr_cnt)
  );

  // behavioural array: one-cycle read latency, write on arr_we, bench poke port
  logic [31:0]      mem_d [0:511];
  logic [PAR_W-1:0] mem_p [0:511];
  logic             poke_en = 1'b0;
  logic [ADDR_W-1:0] poke_addr = '0;
  logic [31:0]      poke_d = '0;
  logic [PAR_W-1:0] poke_p = '0;

  always @(posedge clk) begin
    if (arr_re) begin
      arr_dout <= mem_d[arr_addr];
      arr_pout <= mem_p[arr_addr];
    end
    if (arr_we) begin
      mem_d[arr_addr] <= arr_din;
      mem_p[arr_addr] <= arr_pin;
    end
    if (poke_en) begin
      mem_d[poke_addr] <= poke_d;
      mem_p[poke_addr] <= poke_p;
    end
  end

  // reference state
  logic [31:0]      sh_d [0:511];
  logic [PAR_W-1:0] sh_p [0:511];
  int exp_corr_cnt, exp_uncorr_cnt;
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic bit is_pow2(input int p);
    return (p & (p - 1)) == 0;
  endfunction

  // Hamming + overall parity, straight from the position definition
  function automatic logic [6:0] ref_enc(input logic [31:0] d);
    logic [6:0] c;
    int k;
    c = '0;
    k = 0;
    for (int p = 1; p <= 38; p++) begin
      if (!is_pow2(p)) begin
        for (int i = 0; i < 6; i++) if (((p >> i) & 1) != 0) c[i] = c[i] ^ d[k];
        k++;
      end
    end
    c[6] = (^d) ^ (^c[5:0]);
    return c;
  endfunction

  // 39-bit codeword: index 0 = overall parity, index p = Hamming position p
  function automatic logic [38:0] to_cw(input logic [31:0] d, input logic [6:0] c);
    logic [38:0] cw;
    int k;
    int ci;
    cw = '0;
    k = 0;
    ci = 0;
    cw[0] = c[6];
    for (int p = 1; p <= 38; p++) begin
      if (is_pow2(p)) begin cw[p] = c[ci]; ci++; end
      else begin cw[p] = d[k]; k++; end
    end
    return cw;
  endfunction

  function automatic logic [38:0] from_cw(input logic [38:0] cw);
    logic [31:0] d;
    logic [6:0]  c;
    int k;
    int ci;
    d = '0;
    c = '0;
    k = 0;
    ci = 0;
    c[6] = cw[0];
    for (int p = 1; p <= 38; p++) begin
      if (is_pow2(p)) begin c[ci] = cw[p]; ci++; end
      else begin d[k] = cw[p]; k++; end
    end
    return {d, c};
  endfunction

  // Decode by search: a word is correctable iff exactly one bit flip makes it a valid codeword
  task automatic ref_decode(input logic [31:0] d, input logic [6:0] c,
                            output logic [31:0] od, output bit corr, output bit uncorr);
    logic [38:0] cw;
    logic [38:0] dc;
    od = d;
    corr = 0;
    uncorr = 0;
    if (ref_enc(d) != c) begin
      cw = to_cw(d, c);
      for (int f = 0; f < 39; f++) begin
        dc = from_cw(cw ^ (39'd1 << f));
        if (ref_enc(dc[38:7]) == dc[6:0]) begin
          corr = 1;
          od = dc[38:7];
        end
      end
      uncorr = !corr;
    end
  endtask

  task automatic poke(input logic [ADDR_W-1:0] a, input logic [31:0] d, input logic [PAR_W-1:0] p);
    @(negedge clk);
    poke_en = 1'b1; poke_addr = a; poke_d = d; poke_p = p;
    @(posedge clk);
    #1 poke_en = 1'b0;
    sh_d[a] = d;
    sh_p[a] = p;
  endtask

  // One full read transaction with cycle-accurate expectations
  task automatic do_read(input logic [ADDR_W-1:0] a);
    logic [31:0] ed;
    bit ec, eu;
    logic [6:0] epin;
    ref_decode(sh_d[a], sh_p[a][6:0], ed, ec, eu);
    epin = ref_enc(ed);
    @(negedge clk);
    check("rd_ready_idle", rd_ready, 1);
    rd_valid = 1'b1;
    rd_addr  = a;
    @(posedge clk);
    #1 rd_valid = 1'b0;
    check("rd_ready_read", rd_ready, 0);
    check("arr_re_read", {arr_re, arr_we, arr_addr}, {1'b1, 1'b0, a});
    @(posedge clk);
    #1 check("rsp_valid_check", rsp_valid, 0);
    @(posedge clk);
    #1;
    if (ec && exp_corr_cnt < 65535) exp_corr_cnt++;
    if (eu && exp_uncorr_cnt < 65535) exp_uncorr_cnt++;
    check("rsp_valid", rsp_valid, 1);
    check("rsp_data", rsp_data, ed);
    check("rsp_flags", {rsp_corr, rsp_uncorr}, {ec, eu});
    check("corr_cnt", corr_cnt, exp_corr_cnt);
    check("uncorr_cnt", uncorr_cnt, exp_uncorr_cnt);
    check("sat_corr_cnt", s_corr_cnt, (exp_corr_cnt > 3) ? 3 : exp_corr_cnt);
    check("sat_uncorr_cnt", s_uncorr_cnt, (exp_uncorr_cnt > 3) ? 3 : exp_uncorr_cnt);
    check("arr_we_scrub", arr_we, ec);
    check("rd_ready_rsp", rd_ready, !ec);
    if (ec) begin
      check("scrub_addr", arr_addr, a);
      check("scrub_din", arr_din, ed);
      check("scrub_pin", arr_pin, {9'd0, epin});
      sh_d[a] = ed;
      sh_p[a] = {9'd0, epin};
    end
    @(posedge clk);
    #1;
    check("rsp_valid_drop", rsp_valid, 0);
    check("arr_we_after", arr_we, 0);
    check("rd_ready_back", rd_ready, 1);
    check("rsp_data_hold", rsp_data, ed);
  endtask

  // arr_re and arr_we must never coincide
  always @(negedge clk) begin
    if (rst === 1'b0) check("re_we_excl", arr_re & arr_we, 0);
  end

  initial begin
    logic [31:0] d;
    logic [38:0] cw;
    logic [38:0] dc;
    int nf;
    int pos;
    rst = 1'b1;
    rd_valid = 1'b0;
    rd_addr = '0;
    exp_corr_cnt = 0;
    exp_uncorr_cnt = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", rd_ready, 1);
    check("reset_arr", {arr_re, arr_we, arr_addr, arr_din, arr_pin}, 0);
    check("reset_rsp", {rsp_valid, rsp_corr, rsp_uncorr, rsp_data}, 0);
    check("reset_cnt", {corr_cnt, uncorr_cnt}, 0);
    @(negedge clk);
    rst = 1'b0;

    // directed cases
    poke(0, 32'h0, 16'h0);       do_read(0);   // clean
    poke(1, 32'h1, 16'h0);       do_read(1);   // single data error
    do_read(1);                                // re-read after scrub
    poke(2, 32'h3, 16'h0);       do_read(2);   // double error
    poke(3, 32'h7, 16'h0);       do_read(3);   // triple error aliasing
    poke(4, 32'h0, 16'h0001);    do_read(4);   // check-bit error
    poke(5, 32'h0, 16'h0040);    do_read(5);   // overall-bit error
    poke(6, 32'h0, 16'hFF80);    do_read(6);   // upper check bits ignored

    // randomized words with 0..3 flipped codeword bits
    for (int t = 0; t < 40; t++) begin
      d  = $urandom;
      cw = to_cw(d, ref_enc(d));
      nf = $urandom_range(0, 3);
      for (int j = 0; j < nf; j++) begin
        pos = $urandom_range(0, 38);
        cw[pos] = ~cw[pos];
      end
      dc = from_cw(cw);
      poke(ADDR_W'($urandom_range(0, 31)), 32'h0, 16'h0);
      poke(ADDR_W'(t + 64), dc[38:7], {7'($urandom), 2'($urandom), dc[6:0]});
      do_read(ADDR_W'(t + 64));
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    // reset during CHECK of a correctable read: no scrub afterwards
    poke(7, 32'h0000_0100, 16'h0);
    @(negedge clk);
    rd_valid = 1'b1;
    rd_addr  = 7;
    @(posedge clk);
    #1 rd_valid = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_ready", rd_ready, 1);
    check("midrst_arr", {arr_re, arr_we, arr_addr, arr_din, arr_pin}, 0);
    check("midrst_rsp", {rsp_valid, rsp_corr, rsp_uncorr, rsp_data}, 0);
    check("midrst_cnt", {corr_cnt, uncorr_cnt, s_corr_cnt, s_uncorr_cnt}, 0);
    exp_corr_cnt = 0;
    exp_uncorr_cnt = 0;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1 check("midrst_no_scrub", {arr_we, rsp_valid}, 0);
    end

    // operation resumes; the aborted word is still erroneous
    do_read(7);
    do_read(7);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
